// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM channel mux/demux pair.
// Holds the receiver lock-state type and the default frame geometry.
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam int TDM_NCH    = 8;
    localparam int TDM_DATA_W = 1;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Modulo-NCH slot counter with load-to-1 and last-slot flag.
// Shared by the transmit-side mux and the receive-side demux.
module tdm_slot_ctr
    import tdm_pkg::*;
#(
    parameter int NCH   = TDM_NCH,
    parameter int SEL_W = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_one,
    input  logic             inc,
    output logic [SEL_W-1:0] count,
    output logic             last
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load_one) begin
            count <= SEL_W'(1);
        end else if (inc) begin
            // NCH is a power of 2, so the natural overflow is the modulo wrap.
            count <= count + 1'b1;
        end
    end

    assign last = (count == SEL_W'(NCH - 1));

endmodule

// File: rtl/tdm_demux8.sv
// Receive-side TDM demultiplexer: locks to the slot-0 sync flag, steers
// each slot into a shadow register and publishes complete frames.
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int DATA_W = TDM_DATA_W,
    parameter int NCH    = TDM_NCH,
    parameter int SEL_W  = $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     din,
    input  logic                  din_valid,
    input  logic                  din_sync,
    output logic [NCH*DATA_W-1:0] out_data,
    output logic                  out_valid,
    output logic [NCH-1:0]        ch_strobe,
    output logic [SEL_W-1:0]      slot,
    output logic                  locked,
    output logic                  sync_err
);

    state_t state;
    state_t state_next;

    logic restart;   // beat taken as slot 0 of a fresh frame
    logic normal;    // beat stored at the current slot
    logic misalign;  // sync arrived at a nonzero slot while locked
    logic last;

    // The last slot goes straight into out_data, so it needs no shadow.
    logic [DATA_W-1:0] shadow [NCH-1];

    tdm_slot_ctr #(
        .NCH   (NCH),
        .SEL_W (SEL_W)
    ) u_slot_ctr (
        .clk      (clk),
        .rst      (rst),
        .load_one (restart),
        .inc      (normal),
        .count    (slot),
        .last     (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            HUNT:    if (din_valid && din_sync) state_next = RECV;
            RECV:    state_next = RECV;
            default: state_next = HUNT;
        endcase
    end

    always_comb begin
        restart  = 1'b0;
        normal   = 1'b0;
        misalign = 1'b0;
        locked   = 1'b0;
        unique case (state)
            HUNT: begin
                restart = din_valid && din_sync;
            end
            RECV: begin
                locked   = 1'b1;
                misalign = din_valid && din_sync && (slot != '0);
                restart  = misalign;
                normal   = din_valid && !misalign;
            end
            default: ;
        endcase
    end

    // NOTE: the shadow bank is a handful of flops rather than a RAM, so it
    // is cleared on reset like any other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            ch_strobe <= '0;
            sync_err  <= 1'b0;
            for (int k = 0; k < NCH - 1; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            ch_strobe <= '0;
            sync_err  <= misalign;
            if (restart) begin
                shadow[0] <= din;
                ch_strobe <= NCH'(1);
            end else if (normal) begin
                ch_strobe <= NCH'(1) << slot;
                for (int k = 0; k < NCH - 1; k++) begin
                    if (slot == SEL_W'(k)) shadow[k] <= din;
                end
                if (last) begin
                    out_valid <= 1'b1;
                    for (int k = 0; k < NCH - 1; k++) begin
                        out_data[k*DATA_W +: DATA_W] <= shadow[k];
                    end
                    out_data[(NCH-1)*DATA_W +: DATA_W] <= din;
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux8.sv
// Self-checking bench for tdm_demux8: table-driven first frame, directed
// corner sequences and random stimulus against a frame-level model.
module tb_tdm_demux8;

    localparam int NCH    = 8;
    localparam int DATA_W = 1;
    localparam int SEL_W  = $clog2(NCH);

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [DATA_W-1:0]     din = '0;
    logic                  din_valid = 1'b0;
    logic                  din_sync = 1'b0;
    logic [NCH*DATA_W-1:0] out_data;
    logic                  out_valid;
    logic [NCH-1:0]        ch_strobe;
    logic [SEL_W-1:0]      slot;
    logic                  locked;
    logic                  sync_err;

    int n_vec = 0;
    int n_err = 0;

    tdm_demux8 #(
        .DATA_W (DATA_W),
        .NCH    (NCH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_sync  (din_sync),
        .out_data  (out_data),
        .out_valid (out_valid),
        .ch_strobe (ch_strobe),
        .slot      (slot),
        .locked    (locked),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    // Reference model: frame-level view of the receiver.
    bit                    m_locked;
    int                    m_slot;
    logic [DATA_W-1:0]     m_frame [NCH];
    logic [NCH*DATA_W-1:0] m_out;
    bit                    m_valid;
    bit                    m_err;
    logic [NCH-1:0]        m_strobe;

    task automatic model_step(input logic r, input logic v, input logic s,
                              input logic [DATA_W-1:0] d);
        m_valid  = 1'b0;
        m_err    = 1'b0;
        m_strobe = '0;
        if (r) begin
            m_locked = 1'b0;
            m_slot   = 0;
            m_out    = '0;
            for (int k = 0; k < NCH; k++) m_frame[k] = '0;
            return;
        end
        if (!v) return;
        if (!m_locked && !s) return;
        if (s && (!m_locked || m_slot != 0)) begin
            m_err      = m_locked;
            m_locked   = 1'b1;
            m_frame[0] = d;
            m_strobe   = 1;
            m_slot     = 1;
            return;
        end
        m_frame[m_slot] = d;
        m_strobe = 1 << m_slot;
        if (m_slot == NCH - 1) begin
            m_valid = 1'b1;
            for (int k = 0; k < NCH; k++) m_out[k*DATA_W +: DATA_W] = m_frame[k];
        end
        m_slot = (m_slot + 1) % NCH;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, step the model across the edge, compare every output.
    task automatic apply(input logic r, input logic v, input logic s,
                         input logic [DATA_W-1:0] d);
        rst       = r;
        din_valid = v;
        din_sync  = s;
        din       = d;
        @(posedge clk);
        #1;
        model_step(r, v, s, d);
        check("m_out_data",  64'(out_data),  64'(m_out));
        check("m_out_valid", 64'(out_valid), 64'(m_valid));
        check("m_ch_strobe", 64'(ch_strobe), 64'(m_strobe));
        check("m_slot",      64'(slot),      64'(m_slot));
        check("m_locked",    64'(locked),    64'(m_locked));
        check("m_sync_err",  64'(sync_err),  64'(m_err));
        rst       = 1'b0;
        din_valid = 1'b0;
        din_sync  = 1'b0;
    endtask

    // One aligned frame; checks the strobe walk and the completion pulse.
    task automatic send_frame(input string tag, input logic [NCH*DATA_W-1:0] pat,
                              input bit sync);
        logic [NCH-1:0] oh;
        for (int k = 0; k < NCH; k++) begin
            apply(1'b0, 1'b1, sync && (k == 0), pat[k*DATA_W +: DATA_W]);
            oh = '0;
            oh[k] = 1'b1;
            check({tag, "_strobe"}, 64'(ch_strobe), 64'(oh));
            check({tag, "_valid"}, 64'(out_valid), 64'(k == NCH - 1));
        end
        check({tag, "_data"}, 64'(out_data), 64'(pat));
    endtask

    typedef struct {
        logic                  r;
        logic                  v;
        logic                  s;
        logic [DATA_W-1:0]     d;
        logic [NCH*DATA_W-1:0] e_data;
        logic                  e_valid;
        logic [NCH-1:0]        e_strobe;
        int                    e_slot;
        logic                  e_locked;
        logic                  e_err;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [NCH*DATA_W-1:0] gapless;
        logic [NCH*DATA_W-1:0] pat;

        // Reset then the frame 1,0,1,1,0,0,1,0 with sync on slot 0.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h01, 1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 2, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h04, 3, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h08, 4, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h10, 5, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h20, 6, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h40, 7, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h4D, 1'b1, 8'h80, 0, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h4D, 1'b0, 8'h00, 0, 1'b1, 1'b0};

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d);
            check("t1_data",   64'(out_data),  64'(tbl[i].e_data));
            check("t1_valid",  64'(out_valid), 64'(tbl[i].e_valid));
            check("t1_strobe", 64'(ch_strobe), 64'(tbl[i].e_strobe));
            check("t1_slot",   64'(slot),      64'(tbl[i].e_slot));
            check("t1_locked", 64'(locked),    64'(tbl[i].e_locked));
            check("t1_err",    64'(sync_err),  64'(tbl[i].e_err));
        end

        // Unsynced beats in HUNT are dropped until a synced frame arrives.
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b1, 1'b0, DATA_W'($urandom));
            check("t2_hunt_locked", 64'(locked), 64'(0));
            check("t2_hunt_strobe", 64'(ch_strobe), 64'(0));
            check("t2_hunt_slot", 64'(slot), 64'(0));
        end
        send_frame("t2", 8'h5A, 1'b1);

        // A 3-cycle gap between slots 3 and 4 yields the same frame.
        send_frame("t3_gapless", 8'hB2, 1'b1);
        gapless = out_data;
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        pat = 8'hB2;
        for (int k = 0; k < NCH; k++) begin
            if (k == 4) begin
                for (int g = 0; g < 3; g++) begin
                    apply(1'b0, 1'b0, 1'b0, 1'b0);
                    check("t3_gap_valid", 64'(out_valid), 64'(0));
                    check("t3_gap_slot", 64'(slot), 64'(4));
                end
            end
            apply(1'b0, 1'b1, k == 0, pat[k]);
            check("t3_valid", 64'(out_valid), 64'(k == NCH - 1));
        end
        check("t3_same_as_gapless", 64'(out_data), 64'(gapless));

        // Sync arriving at slot 5 restarts the frame and flags an error.
        for (int k = 0; k < 5; k++) apply(1'b0, 1'b1, k == 0, 1'b1);
        check("t4_pre_slot", 64'(slot), 64'(5));
        pat = 8'hC3;
        apply(1'b0, 1'b1, 1'b1, pat[0]);
        check("t4_err", 64'(sync_err), 64'(1));
        check("t4_slot", 64'(slot), 64'(1));
        check("t4_strobe", 64'(ch_strobe), 64'(1));
        check("t4_no_valid", 64'(out_valid), 64'(0));
        check("t4_data_held", 64'(out_data), 64'(8'hB2));
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_err_pulse", 64'(sync_err), 64'(0));
        for (int k = 1; k < NCH; k++) begin
            apply(1'b0, 1'b1, 1'b0, pat[k]);
            check("t4_valid", 64'(out_valid), 64'(k == NCH - 1));
        end
        check("t4_data", 64'(out_data), 64'(8'hC3));

        // Flywheel: the second frame completes without a sync.
        send_frame("t5_a", 8'hE7, 1'b1);
        send_frame("t5_b", 8'h18, 1'b0);

        // Reset mid-frame (with a colliding beat) clears everything.
        for (int k = 0; k < 4; k++) apply(1'b0, 1'b1, k == 0, 1'b1);
        check("t6_pre_slot", 64'(slot), 64'(4));
        apply(1'b1, 1'b1, 1'b1, 1'b1);
        check("t6_data", 64'(out_data), 64'(0));
        check("t6_valid", 64'(out_valid), 64'(0));
        check("t6_strobe", 64'(ch_strobe), 64'(0));
        check("t6_slot", 64'(slot), 64'(0));
        check("t6_locked", 64'(locked), 64'(0));
        check("t6_err", 64'(sync_err), 64'(0));
        send_frame("t6_after", 8'h96, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(0, 199) == 0,
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 11) == 0,
                  DATA_W'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
